rx_word_unpacker: RTL and testbench
===================================

// Module: rx_word_unpacker
// PURPOSE
//  Downstream consumer of the PC_RX receive FIFO. Pops 32-bit payload words when the FIFO is non-empty,
//  then streams each word as 4 bytes over a valid/ready interface to the data manager / SLM line logic.
//  Counts consumed words per frame and pulses o_frame_done at each frame boundary.
// PARAMETERS
//  FRAME_WORDS  1024  words per frame; word counter wraps to 0 after this many words (>=1)
//  CNT_W        16    width of o_word_count; must satisfy 2**CNT_W > FRAME_WORDS
//  MSB_FIRST    1     1: byte[31:24] sent first; 0: byte[7:0] sent first
// PORTS
//  i_clock              in   1      system clock (50 MHz)
//  i_reset_n            in   1      asynchronous, active-low reset
//  i_flush              in   1      sync flush: drop partial word, clear word count
//  i_fifo_output_word   in   32     FIFO q; valid the cycle after a registered rdreq
//  i_fifo_is_empty_sig  in   1      FIFO empty flag
//  o_read_next_word_cmd out  1      FIFO rdreq; registered, high exactly 1 cycle per pop
//  o_byte_data          out  8      current output byte
//  o_byte_valid         out  1      o_byte_data valid
//  i_byte_ready         in   1      consumer accepts byte when valid & ready at posedge
//  o_word_count         out  CNT_W  words latched in current frame
//  o_frame_done         out  1      1-cycle pulse on acceptance of last byte of word FRAME_WORDS
//  o_busy               out  1      high in any state except IDLE
// BEHAVIOUR
//  Reset (i_reset_n=0, async): state=IDLE, o_read_next_word_cmd=0, o_byte_valid=0, o_byte_data=0,
//   o_word_count=0, o_frame_done=0, o_busy=0, byte index=0, word latch=0. Reset mid-word drops the word.
//  FSM states: IDLE, FETCH, LATCH, SEND.
//   IDLE : if !i_fifo_is_empty_sig -> FETCH with o_read_next_word_cmd=1 in FETCH cycle; else stay.
//   FETCH: rdreq high this cycle only; FIFO pops at end of cycle -> LATCH (rdreq=0).
//   LATCH: capture i_fifo_output_word; word_count+1 (wrap rule below); byte index=0 -> SEND.
//   SEND : o_byte_valid=1; o_byte_data = byte[idx] per MSB_FIRST. On valid&ready: idx+1;
//          on acceptance of idx=3 -> IDLE, o_byte_valid=0 next cycle. No accept -> hold data stable.
//  Empty flag is sampled only in IDLE; never assert rdreq while empty (FIFO underflow forbidden).
//  Latency: empty falling -> rdreq 1 cycle; first byte valid 3 cycles after leaving IDLE.
//   Max throughput: 1 word per 7 cycles with ready held high (IDLE,FETCH,LATCH,4xSEND).
//  o_byte_data registered; o_byte_valid registered; no combinational path ready->valid.
//  Word count: incremented in LATCH; when incremented value == FRAME_WORDS, count loads 0 instead and
//   frame_pending set; o_frame_done pulses the cycle after idx=3 accepted for that word; frame_pending cleared.
//   FRAME_WORDS=1: every word produces o_frame_done, count stays 0.
//  i_flush (priority over all but reset): next cycle state=IDLE, rdreq=0, valid=0, count=0, pending=0.
//   Flush during FETCH: FIFO pop already issued is discarded (word lost, not counted).
//   Flush and FIFO non-empty same cycle: stay IDLE that cycle; fetch resumes next cycle.
//  o_busy = (state != IDLE).
// TESTING
//  1 Reset: assert i_reset_n=0 mid-SEND -> all outputs 0 immediately, state IDLE, no rdreq after release w/ FIFO empty.
//  2 Single word: push 0xA1B2C3D4, ready=1, MSB_FIRST=1 -> one rdreq pulse, bytes A1,B2,C3,D4 on 4
//    consecutive cycles, o_word_count=1.
//  3 Backpressure: ready toggled 1,0,0,1,0,1,1 -> each byte held until accepted, no byte lost/duplicated,
//    exactly one rdreq per word; MSB_FIRST=0 on 0x11223344 -> 44,33,22,11.
//  4 Frame wrap: FRAME_WORDS=4, push 9 words back-to-back -> o_frame_done after bytes of words 4 and 8,
//    o_word_count ends at 1; rdreq never high while empty=1; spacing 7 cycles/word.
//  5 Flush: i_flush during FETCH and during SEND idx=2 -> valid drops next cycle, count=0, next word
//    streamed fully from byte 0.
//  6 Empty drain: FIFO empties after last word -> FSM idles in IDLE, o_busy=0, no spurious rdreq.

Source files
------------

// File: rtl/rx_word_unpacker.sv
// rx_word_unpacker
// Pops 32-bit words from the receive FIFO and streams each one as four bytes
// over a valid/ready interface. Keeps a per-frame word count and pulses
// o_frame_done when the last byte of the final word of a frame is accepted.

module rx_word_unpacker #(
    parameter int FRAME_WORDS = 1024,
    parameter int CNT_W       = 16,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic [31:0]      i_fifo_output_word,
    input  logic             i_fifo_is_empty_sig,
    output logic             o_read_next_word_cmd,
    output logic [7:0]       o_byte_data,
    output logic             o_byte_valid,
    input  logic             i_byte_ready,
    output logic [CNT_W-1:0] o_word_count,
    output logic             o_frame_done,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2,
        SEND  = 2'd3
    } state_t;

    // Count value of the last word in a frame; the word after it wraps to 0.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);
    // Byte lane of the FIFO word that goes out first.
    localparam int FIRST_LANE = MSB_FIRST ? 3 : 0;

    state_t      state;
    logic [31:0] word;
    logic [1:0]  idx;
    logic [1:0]  idx_next;
    logic        pending;
    logic        accept;

    // Latched word split into bytes in transmit order.
    logic [7:0]  word_bytes [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        localparam int SEL = MSB_FIRST ? (3 - gi) : gi;
        assign word_bytes[gi] = word[SEL*8 +: 8];
    end

    assign idx_next = idx + 2'd1;
    assign accept   = o_byte_valid && i_byte_ready;
    assign o_busy   = (state != IDLE);

    // Main control FSM with registered FIFO request, byte stream and counters.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state                <= IDLE;
            word                 <= '0;
            idx                  <= '0;
            pending              <= 1'b0;
            o_read_next_word_cmd <= 1'b0;
            o_byte_data          <= '0;
            o_byte_valid         <= 1'b0;
            o_word_count         <= '0;
            o_frame_done         <= 1'b0;
        end else begin
            o_read_next_word_cmd <= 1'b0;
            o_frame_done         <= 1'b0;
            if (i_flush) begin
                // Abandon whatever is in flight, including a pop already issued.
                state        <= IDLE;
                idx          <= '0;
                pending      <= 1'b0;
                o_byte_valid <= 1'b0;
                o_word_count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        // Empty flag is only looked at here, so no pop can underflow.
                        if (!i_fifo_is_empty_sig) begin
                            state                <= FETCH;
                            o_read_next_word_cmd <= 1'b1;
                        end
                    end
                    FETCH: begin
                        // FIFO pops at the end of this cycle; q is valid next cycle.
                        state <= LATCH;
                    end
                    LATCH: begin
                        word         <= i_fifo_output_word;
                        idx          <= '0;
                        o_byte_valid <= 1'b1;
                        o_byte_data  <= i_fifo_output_word[FIRST_LANE*8 +: 8];
                        if (o_word_count == LAST_CNT) begin
                            o_word_count <= '0;
                            pending      <= 1'b1;
                        end else begin
                            o_word_count <= o_word_count + 1'b1;
                        end
                        state <= SEND;
                    end
                    SEND: begin
                        if (accept) begin
                            if (idx == 2'd3) begin
                                o_byte_valid <= 1'b0;
                                state        <= IDLE;
                                if (pending) begin
                                    o_frame_done <= 1'b1;
                                    pending      <= 1'b0;
                                end
                            end else begin
                                idx         <= idx_next;
                                o_byte_data <= word_bytes[idx_next];
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_word_unpacker.sv
// tb_rx_word_unpacker
// Two instances share one stimulus stream: lane 0 uses FRAME_WORDS=4 with
// MSB-first bytes, lane 1 uses FRAME_WORDS=1 with LSB-first bytes. Each lane
// has its own FIFO read pointer and a scoreboard of expected bytes.

`timescale 1ns/1ps

module tb_rx_word_unpacker;

    localparam int NL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic ready = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int          cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Shared FIFO storage: every push goes to both lanes.
    logic [31:0] fifo_mem [256];
    int          wr_ptr = 0;

    logic       rdreq_s [NL];
    logic [7:0] data_s  [NL];
    logic       valid_s [NL];
    logic       fd_s    [NL];
    logic       busy_s  [NL];
    logic       empty_s [NL];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cycle);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_mem[wr_ptr % 256] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    for (genvar gi = 0; gi < NL; gi++) begin : lane
        localparam int FW  = (gi == 0) ? 4 : 1;
        localparam int CW  = (gi == 0) ? 4 : 2;
        localparam bit MSB = (gi == 0);

        logic [CW-1:0] wc;
        logic [31:0]   q = '0;
        int            rd_ptr = 0;

        assign empty_s[gi] = (wr_ptr == rd_ptr);

        rx_word_unpacker #(
            .FRAME_WORDS(FW),
            .CNT_W      (CW),
            .MSB_FIRST  (MSB)
        ) dut (
            .i_clock             (clk),
            .i_reset_n           (rst_n),
            .i_flush             (flush),
            .i_fifo_output_word  (q),
            .i_fifo_is_empty_sig (empty_s[gi]),
            .o_read_next_word_cmd(rdreq_s[gi]),
            .o_byte_data         (data_s[gi]),
            .o_byte_valid        (valid_s[gi]),
            .i_byte_ready        (ready),
            .o_word_count        (wc),
            .o_frame_done        (fd_s[gi]),
            .o_busy              (busy_s[gi])
        );

        // FIFO read side: q updates on the edge that samples rdreq.
        always @(posedge clk) begin
            if (rdreq_s[gi]) begin
                q      <= fifo_mem[rd_ptr % 256];
                rd_ptr <= rd_ptr + 1;
            end
        end

        // Outputs must clear as soon as reset is asserted, without a clock.
        always @(negedge rst_n) begin
            #1;
            check($sformatf("lane%0d_async_reset_ctl", gi),
                  {28'd0, rdreq_s[gi], valid_s[gi], fd_s[gi], busy_s[gi]}, 32'd0);
            check($sformatf("lane%0d_async_reset_data", gi), {24'd0, data_s[gi]}, 32'd0);
            check($sformatf("lane%0d_async_reset_count", gi), 32'(wc), 32'd0);
        end

        logic [7:0]  exp_q [$];
        int          words      = 0;
        logic        exp_fd     = 1'b0;
        logic        prev_rdreq = 1'b0;
        logic        prev_hold  = 1'b0;
        logic        prev_cont  = 1'b0;
        logic        flushed    = 1'b0;
        logic        lat1       = 1'b0;
        logic        lat2       = 1'b0;
        logic [7:0]  prev_data  = '0;
        logic [31:0] pw;
        logic [31:0] sh;

        // Reference model: checks the result of the last edge, then predicts the next one.
        always @(negedge clk) begin
            if (!rst_n) begin
                check($sformatf("lane%0d_reset_ctl", gi),
                      {28'd0, rdreq_s[gi], valid_s[gi], fd_s[gi], busy_s[gi]}, 32'd0);
                check($sformatf("lane%0d_reset_data", gi), {24'd0, data_s[gi]}, 32'd0);
                check($sformatf("lane%0d_reset_count", gi), 32'(wc), 32'd0);
                exp_q.delete();
                words      = 0;
                exp_fd     = 1'b0;
                prev_rdreq = 1'b0;
                prev_hold  = 1'b0;
                prev_cont  = 1'b0;
                flushed    = 1'b0;
                lat1       = 1'b0;
                lat2       = 1'b0;
            end else begin
                check($sformatf("lane%0d_frame_done", gi), {31'd0, fd_s[gi]}, {31'd0, exp_fd});
                if (prev_rdreq)
                    check($sformatf("lane%0d_rdreq_pulse", gi), {31'd0, rdreq_s[gi]}, 32'd0);
                if (flushed) begin
                    check($sformatf("lane%0d_flush_valid", gi), {31'd0, valid_s[gi]}, 32'd0);
                    check($sformatf("lane%0d_flush_rdreq", gi), {31'd0, rdreq_s[gi]}, 32'd0);
                    check($sformatf("lane%0d_flush_count", gi), 32'(wc), 32'd0);
                end
                if (prev_hold) begin
                    check($sformatf("lane%0d_hold_valid", gi), {31'd0, valid_s[gi]}, 32'd1);
                    check($sformatf("lane%0d_hold_data", gi), {24'd0, data_s[gi]}, {24'd0, prev_data});
                end
                if (prev_cont)
                    check($sformatf("lane%0d_stream_valid", gi), {31'd0, valid_s[gi]}, 32'd1);
                if (lat2)
                    check($sformatf("lane%0d_latency_valid", gi), {31'd0, valid_s[gi]}, 32'd1);
                if (empty_s[gi])
                    check($sformatf("lane%0d_underflow", gi), {31'd0, rdreq_s[gi]}, 32'd0);
                if (valid_s[gi])
                    check($sformatf("lane%0d_busy", gi), {31'd0, busy_s[gi]}, 32'd1);

                exp_fd     = 1'b0;
                prev_hold  = 1'b0;
                prev_cont  = 1'b0;
                flushed    = flush;
                lat2       = lat1 && !flush;
                lat1       = rdreq_s[gi] && !flush;
                prev_rdreq = rdreq_s[gi];

                if (flush) begin
                    exp_q.delete();
                    words = 0;
                end else begin
                    if (valid_s[gi] && ready) begin
                        if (exp_q.size() == 0) begin
                            check($sformatf("lane%0d_spurious_byte", gi), 32'd1, 32'd0);
                        end else begin
                            check($sformatf("lane%0d_byte", gi), {24'd0, data_s[gi]}, {24'd0, exp_q[0]});
                            check($sformatf("lane%0d_word_count", gi), 32'(wc), 32'(words % FW));
                            void'(exp_q.pop_front());
                            if (exp_q.size() == 0) begin
                                exp_fd = ((words % FW) == 0);
                                $display("lane %0d: word %0d done, count %0d, frame_done expected %0b",
                                         gi, words, wc, exp_fd);
                            end else begin
                                prev_cont = 1'b1;
                            end
                        end
                    end else if (valid_s[gi]) begin
                        prev_hold = 1'b1;
                        prev_data = data_s[gi];
                    end
                    if (rdreq_s[gi]) begin
                        pw    = fifo_mem[rd_ptr % 256];
                        words = words + 1;
                        for (int k = 0; k < 4; k++) begin
                            sh = MSB ? (pw >> (24 - 8 * k)) : (pw >> (8 * k));
                            exp_q.push_back(sh[7:0]);
                        end
                    end
                end
            end
        end
    end

    function automatic logic drained();
        return empty_s[0] && empty_s[1] && !busy_s[0] && !busy_s[1];
    endfunction

    task automatic wait_drain(input int max_cycles);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(posedge clk);
            #1;
            if (drained()) done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input int which, input int max_cycles);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            step();
            if ((which == 0 && rdreq_s[0]) || (which == 1 && valid_s[0])) done = 1'b1;
        end
        if (!done) check("event_timeout", 32'd0, 32'd1);
    endtask

    logic [6:0] pat = 7'b1101001;
    int         rd_times [$];
    int         fd_cnt0;
    int         fd_cnt1;
    logic       done_loop;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single word with ready held high.
        ready = 1'b1;
        push_word(32'hA1B2C3D4);
        wait_drain(50);
        check("single_count_lane0", 32'(lane[0].wc), 32'd1);
        check("single_count_lane1", 32'(lane[1].wc), 32'd0);

        // Backpressure with the 1,0,0,1,0,1,1 ready pattern.
        push_word(32'h11223344);
        for (int i = 0; i < 3; i++) push_word($urandom);
        done_loop = 1'b0;
        for (int c = 0; c < 400 && !done_loop; c++) begin
            @(posedge clk);
            #1;
            ready = pat[c % 7];
            if (drained()) done_loop = 1'b1;
        end
        if (!done_loop) check("backpressure_timeout", 32'd0, 32'd1);
        ready = 1'b1;
        step();

        // Frame wrap: nine back-to-back words after a flush.
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 9; i++) push_word($urandom);
        fd_cnt0   = 0;
        fd_cnt1   = 0;
        done_loop = 1'b0;
        rd_times.delete();
        for (int c = 0; c < 200 && !done_loop; c++) begin
            @(negedge clk);
            if (rdreq_s[0]) rd_times.push_back(cycle);
            if (fd_s[0]) fd_cnt0++;
            if (fd_s[1]) fd_cnt1++;
            if (drained()) done_loop = 1'b1;
        end
        if (!done_loop) check("wrap_timeout", 32'd0, 32'd1);
        check("wrap_pops", 32'(rd_times.size()), 32'd9);
        for (int i = 1; i < rd_times.size(); i++)
            check("wrap_spacing", 32'(rd_times[i] - rd_times[i-1]), 32'd7);
        check("wrap_frames_lane0", 32'(fd_cnt0), 32'd2);
        check("wrap_frames_lane1", 32'(fd_cnt1), 32'd9);
        check("wrap_count_lane0", 32'(lane[0].wc), 32'd1);

        // Flush during FETCH: the popped word is lost.
        @(posedge clk);
        #1;
        push_word(32'hDEADBEEF);
        wait_sig(0, 20);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fetch_flush_valid", {31'd0, valid_s[0]}, 32'd0);
        check("fetch_flush_count", 32'(lane[0].wc), 32'd0);
        push_word($urandom);
        wait_drain(50);
        check("fetch_flush_next_count", 32'(lane[0].wc), 32'd1);

        // Flush while the third byte is on the bus.
        push_word($urandom);
        wait_sig(1, 20);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("send_flush_valid", {31'd0, valid_s[0]}, 32'd0);
        check("send_flush_count", 32'(lane[0].wc), 32'd0);
        push_word($urandom);
        wait_drain(50);
        check("send_flush_next_count", 32'(lane[0].wc), 32'd1);

        // Flush in the same cycle the FIFO becomes non-empty.
        push_word($urandom);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("idle_flush_busy", {31'd0, busy_s[0]}, 32'd0);
        wait_drain(50);

        // Asynchronous reset in the middle of a word, FIFO then empty.
        ready = 1'b0;
        push_word($urandom);
        wait_sig(1, 20);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("post_reset_rdreq", {31'd0, rdreq_s[0]}, 32'd0);
            check("post_reset_busy", {31'd0, busy_s[0]}, 32'd0);
        end

        // Randomized traffic with occasional flushes.
        for (int c = 0; c < 1500; c++) begin
            step();
            ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0 && (wr_ptr - lane[0].rd_ptr) < 200 && (wr_ptr - lane[1].rd_ptr) < 200)
                push_word($urandom);
        end
        flush = 1'b0;
        ready = 1'b1;
        wait_drain(3000);

        // Drained FIFO: the block stays idle and quiet.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("drain_busy0", {31'd0, busy_s[0]}, 32'd0);
            check("drain_busy1", {31'd0, busy_s[1]}, 32'd0);
            check("drain_rdreq0", {31'd0, rdreq_s[0]}, 32'd0);
            check("drain_rdreq1", {31'd0, rdreq_s[1]}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
